// File: rtl/potential_adder_array_pkg.sv
// Shared definitions for the LIF membrane-update engine.
//   - FSM state encodings
//   - floating-point constants (FP_ZERO, DEFAULT_VTH, FP_QNAN)
//   - reset-mode encodings
//   - fp_add_sub: IEEE-754 single add/subtract, returns {exception, result}
package potential_adder_array_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEPT = 3'd1;
  localparam logic [2:0] ST_CALC   = 3'd2;
  localparam logic [2:0] ST_EMIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] DEFAULT_VTH = 32'h4220_0000;  // 40.0

  localparam logic RST_MODE_SUB  = 1'b0;  // subtract threshold on spike
  localparam logic RST_MODE_ZERO = 1'b1;  // reset potential to zero

  // Round-to-nearest-even single-precision add (sub = 1 gives a - b).
  // Exception is raised whenever the result exponent is all ones
  // (inf/NaN operands, inf - inf, or overflow).
  function automatic logic [32:0] fp_add_sub(input logic [31:0] a_in,
                                             input logic [31:0] b_in,
                                             input logic        sub);
    logic [31:0] a, b, x, y;
    logic [9:0]  ex, ey, e;
    logic [23:0] mx, my;
    logic [7:0]  d;
    logic [49:0] al;
    logic [26:0] xx, yy;
    logic [27:0] s;
    logic [4:0]  lz, sh;
    logic [24:0] m;
    logic        rnd;
    a = a_in;
    b = {b_in[31] ^ sub, b_in[30:0]};
    if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) begin
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) ||
          (b[30:23] == 8'hFF && b[22:0] != 23'd0))
        return {1'b1, FP_QNAN};
      if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31])
        return {1'b1, FP_QNAN};
      return {1'b1, (a[30:23] == 8'hFF) ? a : b};
    end
    // Order by magnitude so the aligned difference is never negative.
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    ex = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
    ey = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
    mx = {x[30:23] != 8'd0, x[22:0]};
    my = {y[30:23] != 8'd0, y[22:0]};
    d  = 8'(ex - ey);
    // Alignment keeps guard and round bits; everything below folds into sticky.
    al = {my, 26'd0} >> ((d > 8'd31) ? 8'd31 : d);
    yy = {al[49:24], |al[23:0]};
    xx = {mx, 3'b000};
    s  = (x[31] == y[31]) ? ({1'b0, xx} + {1'b0, yy}) : ({1'b0, xx} - {1'b0, yy});
    e  = ex;
    if (s == 28'd0) return {1'b0, FP_ZERO};
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      lz = 5'd0;
      for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
      // Stop normalising at the minimum exponent: result stays subnormal.
      sh = ({5'd0, lz} >= e) ? 5'(e - 10'd1) : lz;
      s  = s << sh;
      e  = e - {5'd0, sh};
    end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    m   = {1'b0, s[26:3]} + {24'd0, rnd};
    if (m[24]) begin
      m = {1'b0, m[24:1]};
      e = e + 10'd1;
    end
    if (e >= 10'd255) return {1'b1, x[31], 8'hFF, 23'd0};
    return {1'b0, x[31], (m[23] ? e[7:0] : 8'h00), m[22:0]};
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational LIF update for one neuron.
//   op_weight, op_potential : summed weight and decayed potential (float)
//   vth, reset_mode         : firing threshold and reset behaviour
//   potential               : updated potential (reset value on spike, else raw sum)
//   spike                   : sum strictly above threshold and no exception
//   exc                     : exception from either the add or the threshold subtract
module lif_update_core
  import potential_adder_array_pkg::*;
(
  input  logic [31:0] op_weight,
  input  logic [31:0] op_potential,
  input  logic [31:0] vth,
  input  logic        reset_mode,
  output logic [31:0] potential,
  output logic        spike,
  output logic        exc
);

  logic [32:0] add_res;
  logic [32:0] sub_res;
  logic [31:0] sum;
  logic [31:0] rst_val;
  logic        greater;

  assign add_res = fp_add_sub(op_weight, op_potential, 1'b0);
  assign sum     = add_res[31:0];
  assign sub_res = fp_add_sub(sum, vth, 1'b1);
  assign rst_val = (reset_mode == RST_MODE_ZERO) ? FP_ZERO : sub_res[31:0];
  assign exc     = add_res[32] | sub_res[32];

  // Sign-magnitude compare; +0 and -0 are equal.
  always_comb begin
    greater = 1'b0;
    if (sum[30:0] == 31'd0 && vth[30:0] == 31'd0) greater = 1'b0;
    else if (sum[31] != vth[31])                  greater = ~sum[31];
    else if (!sum[31])                            greater = sum[30:0] > vth[30:0];
    else                                          greater = sum[30:0] < vth[30:0];
  end

  assign spike     = greater & ~exc;
  assign potential = spike ? rst_val : sum;

endmodule

// File: rtl/potential_adder_array.sv
// Time-multiplexed LIF membrane-update engine.
//   CLK, RESET_N            : clock, asynchronous active-low reset
//   cfg_we/cfg_threshold/cfg_reset_mode : configuration, taken in IDLE only
//   start, busy, done       : frame control and status
//   in_valid/in_ready/in_weight/in_potential : operand stream, one pair per neuron
//   out_valid/out_ready/out_idx/out_potential/out_spike : result stream
//   spike_vec               : spikes of the last completed frame
//   exception               : sticky add/sub exception flag for the frame
module potential_adder_array #(
  parameter int          NUM_NEURONS        = 30,
  parameter int          IDX_W              = $clog2(NUM_NEURONS),
  parameter logic [31:0] DEFAULT_VTH        = potential_adder_array_pkg::DEFAULT_VTH,
  parameter logic        DEFAULT_RESET_MODE = potential_adder_array_pkg::RST_MODE_SUB
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   cfg_we,
  input  logic [31:0]            cfg_threshold,
  input  logic                   cfg_reset_mode,
  input  logic                   start,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_weight,
  input  logic [31:0]            in_potential,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_idx,
  output logic [31:0]            out_potential,
  output logic                   out_spike,
  output logic [NUM_NEURONS-1:0] spike_vec,
  output logic                   done,
  output logic                   exception
);
  import potential_adder_array_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  logic [2:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [31:0]            w_q, w_d, v_q, v_d;
  logic [31:0]            pot_q, pot_d;
  logic                   spike_q, spike_d;
  logic                   exc_q, exc_d;
  logic [NUM_NEURONS-1:0] spike_vec_q, spike_vec_d;
  logic [31:0]            vth_q, vth_d;
  logic                   mode_q, mode_d;

  logic [31:0] core_potential;
  logic        core_spike;
  logic        core_exc;

  lif_update_core u_core (
    .op_weight    (w_q),
    .op_potential (v_q),
    .vth          (vth_q),
    .reset_mode   (mode_q),
    .potential    (core_potential),
    .spike        (core_spike),
    .exc          (core_exc)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    w_d         = w_q;
    v_d         = v_q;
    pot_d       = pot_q;
    spike_d     = spike_q;
    exc_d       = exc_q;
    spike_vec_d = spike_vec_q;
    vth_d       = vth_q;
    mode_d      = mode_q;
    case (state_q)
      ST_IDLE: begin
        // Config lands on the same edge as start, so a combined write applies to this frame.
        if (cfg_we) begin
          vth_d  = cfg_threshold;
          mode_d = cfg_reset_mode;
        end
        if (start) begin
          state_d     = ST_ACCEPT;
          spike_vec_d = '0;
          exc_d       = 1'b0;
          idx_d       = '0;
        end
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          w_d     = in_weight;
          v_d     = in_potential;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        pot_d   = core_potential;
        spike_d = core_spike;
        exc_d   = exc_q | core_exc;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          spike_vec_d[idx_q] = spike_q;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      w_q         <= FP_ZERO;
      v_q         <= FP_ZERO;
      pot_q       <= FP_ZERO;
      spike_q     <= 1'b0;
      exc_q       <= 1'b0;
      spike_vec_q <= '0;
      vth_q       <= DEFAULT_VTH;
      mode_q      <= DEFAULT_RESET_MODE;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      w_q         <= w_d;
      v_q         <= v_d;
      pot_q       <= pot_d;
      spike_q     <= spike_d;
      exc_q       <= exc_d;
      spike_vec_q <= spike_vec_d;
      vth_q       <= vth_d;
      mode_q      <= mode_d;
    end
  end

  assign busy          = (state_q == ST_ACCEPT) || (state_q == ST_CALC) || (state_q == ST_EMIT);
  assign in_ready      = (state_q == ST_ACCEPT);
  assign out_valid     = (state_q == ST_EMIT);
  assign done          = (state_q == ST_DONE);
  assign out_idx       = idx_q;
  assign out_potential = pot_q;
  assign out_spike     = spike_q;
  assign spike_vec     = spike_vec_q;
  assign exception     = exc_q;

endmodule

// File: tb/tb_potential_adder_array.sv
// Directed bench for potential_adder_array with four neurons per frame.
module tb_potential_adder_array;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [31:0]   cfg_threshold;
  logic          cfg_reset_mode;
  logic          start;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_weight;
  logic [31:0]   in_potential;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic [31:0]   out_potential;
  logic          out_spike;
  logic [N-1:0]  spike_vec;
  logic          done;
  logic          exception;

  int total = 0;
  int bad   = 0;

  potential_adder_array #(.NUM_NEURONS(N)) dut (
    .CLK            (clk),
    .RESET_N        (rst_n),
    .cfg_we         (cfg_we),
    .cfg_threshold  (cfg_threshold),
    .cfg_reset_mode (cfg_reset_mode),
    .start          (start),
    .busy           (busy),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_weight      (in_weight),
    .in_potential   (in_potential),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_idx        (out_idx),
    .out_potential  (out_potential),
    .out_spike      (out_spike),
    .spike_vec      (spike_vec),
    .done           (done),
    .exception      (exception)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one pair, then wait for the result. lat is the cycle number of
  // the first out_valid relative to the handshake cycle (bounded wait).
  task automatic drive_pair(input logic [31:0] w, input logic [31:0] v, output int lat);
    int n;
    in_weight    = w;
    in_potential = v;
    in_valid     = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_potential !== 32'h0) begin bad++; $display("FAIL reset_out_potential got=%h want=0", out_potential); end
    total++; if (spike_vec !== 4'b0) begin bad++; $display("FAIL reset_spike_vec got=%b want=0", spike_vec); end
    total++; if (done !== 1'b0 || exception !== 1'b0 || out_spike !== 1'b0 || out_idx !== 2'd0)
      begin bad++; $display("FAIL reset_misc got done=%b exc=%b spk=%b idx=%0d want all 0", done, exception, out_spike, out_idx); end
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready got=%b want=0", in_ready); end
  endtask

  task automatic test_frame_mode0();
    logic [31:0] w[N]  = '{32'h41200000, 32'h41A00000, 32'h41700000, 32'h41A00000};
    logic [31:0] v[N]  = '{32'h41C80000, 32'h41C80000, 32'h41C80000, 32'h41C80000};
    logic [31:0] ep[N] = '{32'h420C0000, 32'h40A00000, 32'h42200000, 32'h40A00000};
    logic        es[N] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int lat;
    start = 1'b1; tick(); start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL m0_busy_after_start got=%b want=1", busy); end
    for (int i = 0; i < N; i++) begin
      drive_pair(w[i], v[i], lat);
      $display("m0 neuron %0d idx=%0d pot=%h spike=%b lat=%0d", i, out_idx, out_potential, out_spike, lat);
      total++; if (lat != 2) begin bad++; $display("FAIL m0_latency n%0d got=%0d want=2", i, lat); end
      total++; if (out_idx !== IW'(i)) begin bad++; $display("FAIL m0_idx n%0d got=%0d want=%0d", i, out_idx, i); end
      total++; if (out_potential !== ep[i]) begin bad++; $display("FAIL m0_pot n%0d got=%h want=%h", i, out_potential, ep[i]); end
      total++; if (out_spike !== es[i]) begin bad++; $display("FAIL m0_spike n%0d got=%b want=%b", i, out_spike, es[i]); end
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL m0_done got=%b want=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL m0_busy_at_done got=%b want=0", busy); end
    total++; if (spike_vec !== 4'b1010) begin bad++; $display("FAIL m0_spike_vec got=%b want=1010", spike_vec); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL m0_done_pulse got=%b want=0", done); end
    total++; if (spike_vec !== 4'b1010) begin bad++; $display("FAIL m0_spike_vec_hold got=%b want=1010", spike_vec); end
  endtask

  task automatic test_back_pressure();
    int lat;
    cfg_we = 1'b1; cfg_threshold = 32'h42200000; cfg_reset_mode = 1'b1; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    out_ready = 1'b0;
    drive_pair(32'h41A00000, 32'h41C80000, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL bp_latency got=%0d want=2", lat); end
    for (int k = 0; k < 5; k++) begin
      tick();
      $display("bp stall %0d valid=%b idx=%0d pot=%h spike=%b in_ready=%b", k, out_valid, out_idx, out_potential, out_spike, in_ready);
      total++;
      if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_potential !== 32'h0 || out_spike !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold c%0d got valid=%b idx=%0d pot=%h spk=%b rdy=%b want 1 0 00000000 1 0",
                 k, out_valid, out_idx, out_potential, out_spike, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    for (int i = 1; i < N; i++) begin
      drive_pair(32'h41200000, 32'h41C80000, lat);
      $display("m1 neuron %0d idx=%0d pot=%h spike=%b", i, out_idx, out_potential, out_spike);
      total++; if (out_potential !== 32'h420C0000 || out_spike !== 1'b0)
        begin bad++; $display("FAIL m1_result n%0d got pot=%h spk=%b want 420c0000 0", i, out_potential, out_spike); end
      tick();
    end
    total++; if (done !== 1'b1 || spike_vec !== 4'b0001)
      begin bad++; $display("FAIL m1_done got done=%b vec=%b want 1 0001", done, spike_vec); end
    tick();
  endtask

  task automatic test_negative_and_exception();
    logic [31:0] w[N]  = '{32'hC1200000, 32'hC1A00000, 32'h7F800000, 32'h41200000};
    logic [31:0] v[N]  = '{32'hC1C80000, 32'hC1C80000, 32'h41C80000, 32'h41C80000};
    logic [31:0] ep[N] = '{32'h40A00000, 32'hC2340000, 32'h7F800000, 32'h42960000};
    logic        es[N] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int lat;
    cfg_we = 1'b1; cfg_threshold = 32'hC2200000; cfg_reset_mode = 1'b0;
    tick();
    cfg_we = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      drive_pair(w[i], v[i], lat);
      $display("neg neuron %0d pot=%h spike=%b exc=%b", i, out_potential, out_spike, exception);
      total++; if (out_potential !== ep[i] || out_spike !== es[i])
        begin bad++; $display("FAIL neg_result n%0d got pot=%h spk=%b want %h %b", i, out_potential, out_spike, ep[i], es[i]); end
      tick();
    end
    total++; if (spike_vec !== 4'b1001) begin bad++; $display("FAIL neg_spike_vec got=%b want=1001", spike_vec); end
    total++; if (exception !== 1'b1) begin bad++; $display("FAIL neg_exception got=%b want=1", exception); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int lat;
    start = 1'b1; tick(); start = 1'b0;
    total++; if (exception !== 1'b0) begin bad++; $display("FAIL mid_exc_cleared got=%b want=0", exception); end
    for (int i = 0; i < 3; i++) begin
      drive_pair(32'h41A00000, 32'h41C80000, lat);
      $display("mid neuron %0d pot=%h spike=%b", i, out_potential, out_spike);
      total++; if (out_potential !== 32'h42AA0000 || out_spike !== 1'b1)
        begin bad++; $display("FAIL mid_result n%0d got pot=%h spk=%b want 42aa0000 1", i, out_potential, out_spike); end
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_potential !== 32'h0 ||
        out_spike !== 1'b0 || spike_vec !== 4'b0 || out_idx !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs got busy=%b rdy=%b val=%b pot=%h spk=%b vec=%b idx=%0d want all 0",
               busy, in_ready, out_valid, out_potential, out_spike, spike_vec, out_idx);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    // Config write and start while busy must be ignored.
    cfg_we = 1'b1; cfg_threshold = 32'h00000000; cfg_reset_mode = 1'b1; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b1 || in_ready !== 1'b1 || out_idx !== 2'd0)
      begin bad++; $display("FAIL ign_state got busy=%b rdy=%b idx=%0d want 1 1 0", busy, in_ready, out_idx); end
    drive_pair(32'h41A00000, 32'h41C80000, lat);
    $display("restart neuron 0 idx=%0d pot=%h spike=%b", out_idx, out_potential, out_spike);
    total++; if (out_idx !== 2'd0 || out_potential !== 32'h40A00000 || out_spike !== 1'b1)
      begin bad++; $display("FAIL restart_n0 got idx=%0d pot=%h spk=%b want 0 40a00000 1", out_idx, out_potential, out_spike); end
    tick();
    drive_pair(32'h41200000, 32'h41C80000, lat);
    $display("restart neuron 1 idx=%0d pot=%h spike=%b", out_idx, out_potential, out_spike);
    total++; if (out_idx !== 2'd1 || out_potential !== 32'h420C0000 || out_spike !== 1'b0)
      begin bad++; $display("FAIL restart_n1 got idx=%0d pot=%h spk=%b want 1 420c0000 0", out_idx, out_potential, out_spike); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_threshold = 32'h0; cfg_reset_mode = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_weight = 32'h0; in_potential = 32'h0; out_ready = 1'b1;
    test_reset();
    test_frame_mode0();
    test_back_pressure();
    test_negative_and_exception();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
